// File: rtl/mux_81_rr_arbiter.sv
// Round-robin arbiter in front of an 8:1 mux: grants one of eight requesters,
// drives the mux selects to its index and bounds each grant with a hold timeout.
module mux_81_rr_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic       valid,
  output logic       s0,
  output logic       s1,
  output logic       s2,
  output logic       timeout
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  // With MAX_HOLD=0 this wraps to all-ones, so the counter simply saturates at its max.
  localparam logic [CNT_W-1:0] HoldLast = CNT_W'(MAX_HOLD - 1);

  logic [0:0]       state_q, state_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [2:0]       sel_q, sel_d;
  logic [7:0]       gnt_q, gnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  logic [2:0] pickIdx;
  logic [2:0] scanIdx;
  logic       pickFound;
  logic       capHit;
  logic       release_;

  // Scan from the farthest slot back toward ptr so the closest requester wins.
  always_comb begin
    pickIdx   = ptr_q;
    pickFound = 1'b0;
    scanIdx   = ptr_q;
    for (int d = 7; d >= 0; d--) begin
      scanIdx = ptr_q + 3'(d);
      if (req[scanIdx]) begin
        pickIdx   = scanIdx;
        pickFound = 1'b1;
      end
    end
  end

  assign capHit   = (MAX_HOLD != 0) && (cnt_q == HoldLast);
  assign release_ = done || !req[sel_q] || capHit;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    gnt_d     = gnt_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pickFound) begin
          state_d = GRANT;
          sel_d   = pickIdx;
          gnt_d   = 8'b1 << pickIdx;
          cnt_d   = '0;
        end
      end
      default: begin
        if (cnt_q != HoldLast) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (release_) begin
          state_d   = IDLE;
          gnt_d     = 8'h00;
          ptr_d     = sel_q + 3'd1;
          timeout_d = capHit && !done && req[sel_q];
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= 3'd0;
      sel_q     <= 3'd0;
      gnt_q     <= 8'h00;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      gnt_q     <= gnt_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt     = gnt_q;
  assign valid   = (state_q == GRANT);
  assign s0      = sel_q[2];
  assign s1      = sel_q[1];
  assign s2      = sel_q[0];
  assign timeout = timeout_q;

endmodule
